// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-1 microcode sequencer.
// A T-state counter plus opcode decode drives the datapath control strobes.
// The same block holds the C/Z flags and the halt latch. State advances only
// on clock edges where step_en is high, and rst_n is a synchronous active-low reset.
// Optional feature macro: SEQ_EARLY_END_EN. When it is defined, each instruction
// returns to T0 right after its last non-empty micro-step. When it is not defined,
// every instruction runs the full T0..LAST_STEP sequence.
module sap_control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int STEP_W    = 3,
  parameter int LAST_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_c,
  input  logic                alu_z,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_jump,
  output logic                mar_in,
  output logic                ram_out,
  output logic                ram_in,
  output logic                ir_in,
  output logic                ir_out,
  output logic                a_in,
  output logic                a_out,
  output logic                b_in,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                out_in,
  output logic [STEP_W-1:0]   t_state,
  output logic                c_flag,
  output logic                z_flag,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0011);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0111);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  localparam logic [STEP_W-1:0] T0    = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1    = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2    = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3    = STEP_W'(3);
  localparam logic [STEP_W-1:0] T_END = STEP_W'(LAST_STEP);

`ifdef SEQ_EARLY_END_EN
  // Index of the last micro-step that does any work for the given opcode.
  function automatic logic [STEP_W-1:0] end_step(input logic [OPCODE_W-1:0] op);
    logic [STEP_W-1:0] s;
    s = T2;
    if (op == OP_LDA || op == OP_STA) s = T3;
    if (op == OP_ADD || op == OP_SUB) s = T_END;
    return s;
  endfunction
`endif

  logic [STEP_W-1:0] t_next;
  logic              c_next;
  logic              z_next;
  logic              halt_next;

  // State register: synchronous reset, otherwise load the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_state <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      c_flag  <= c_next;
      z_flag  <= z_next;
      halted  <= halt_next;
    end
  end

  // Next state: advance, wrap, halt and flag capture, all gated by step_en.
  always_comb begin
    t_next    = t_state;
    c_next    = c_flag;
    z_next    = z_flag;
    halt_next = halted;
    if (step_en && !halted) begin
      // HLT freezes the counter at T2 instead of advancing it.
      if (t_state == T2 && opcode == OP_HLT) begin
        halt_next = 1'b1;
      end else if (t_state == T_END) begin
        t_next = T0;
`ifdef SEQ_EARLY_END_EN
      end else if (t_state == end_step(opcode)) begin
        t_next = T0;
`endif
      end else begin
        t_next = t_state + STEP_W'(1);
      end
      // Flags follow only the arithmetic instructions, captured on their final step.
      if (t_state == T_END && (opcode == OP_ADD || opcode == OP_SUB)) begin
        c_next = alu_c;
        z_next = alu_z;
      end
    end
  end

  // Control decode: fetch in T0/T1, opcode-specific execute in T2..T4.
  always_comb begin
    pc_out  = 1'b0;
    pc_inc  = 1'b0;
    pc_jump = 1'b0;
    mar_in  = 1'b0;
    ram_out = 1'b0;
    ram_in  = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    a_in    = 1'b0;
    a_out   = 1'b0;
    b_in    = 1'b0;
    alu_out = 1'b0;
    alu_sub = 1'b0;
    out_in  = 1'b0;
    if (!halted) begin
      if (t_state == T0) begin
        pc_out = 1'b1;
        mar_in = 1'b1;
      end else if (t_state == T1) begin
        ram_out = 1'b1;
        ir_in   = 1'b1;
        pc_inc  = 1'b1;
      end else if (t_state == T2) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_out = 1'b1;
            mar_in = 1'b1;
          end
          OP_LDI: begin
            ir_out = 1'b1;
            a_in   = 1'b1;
          end
          OP_JMP: begin
            ir_out  = 1'b1;
            pc_jump = 1'b1;
          end
          // Conditional jumps use the registered flags, never the live ALU outputs.
          OP_JC: begin
            ir_out  = 1'b1;
            pc_jump = c_flag;
          end
          OP_JZ: begin
            ir_out  = 1'b1;
            pc_jump = z_flag;
          end
          OP_OUT: begin
            a_out  = 1'b1;
            out_in = 1'b1;
          end
          default: ;
        endcase
      end else if (t_state == T3) begin
        case (opcode)
          OP_LDA: begin
            ram_out = 1'b1;
            a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_out = 1'b1;
            b_in    = 1'b1;
          end
          OP_STA: begin
            a_out  = 1'b1;
            ram_in = 1'b1;
          end
          default: ;
        endcase
      end else if (t_state == T_END) begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_out = 1'b1;
          a_in    = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
      end
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed scoreboard bench for sap_control_sequencer.
// The stimulus process pushes the expected state into a queue after each action.
// A separate monitor pops that entry and compares it against the DUT.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_en;
  logic [3:0] opcode;
  logic       alu_c;
  logic       alu_z;
  logic       pc_out, pc_inc, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, out_in;
  logic [2:0] t_state;
  logic       c_flag, z_flag, halted;

  sap_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .opcode(opcode),
    .alu_c(alu_c), .alu_z(alu_z),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_jump(pc_jump), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_in(out_in), .t_state(t_state),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  // Control bit positions within the 14-bit expected-control word.
  localparam logic [13:0] PC_OUT  = 14'h2000;
  localparam logic [13:0] PC_INC  = 14'h1000;
  localparam logic [13:0] PC_JUMP = 14'h0800;
  localparam logic [13:0] MAR_IN  = 14'h0400;
  localparam logic [13:0] RAM_OUT = 14'h0200;
  localparam logic [13:0] RAM_IN  = 14'h0100;
  localparam logic [13:0] IR_IN   = 14'h0080;
  localparam logic [13:0] IR_OUT  = 14'h0040;
  localparam logic [13:0] A_IN    = 14'h0020;
  localparam logic [13:0] A_OUT   = 14'h0010;
  localparam logic [13:0] B_IN    = 14'h0008;
  localparam logic [13:0] ALU_OUT = 14'h0004;
  localparam logic [13:0] ALU_SUB = 14'h0002;
  localparam logic [13:0] OUT_IN  = 14'h0001;
  localparam logic [13:0] FETCH0  = PC_OUT | MAR_IN;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  wire [19:0] observed = {pc_out, pc_inc, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out,
                          a_in, a_out, b_in, alu_out, alu_sub, out_in,
                          t_state, c_flag, z_flag, halted};

  // Monitor: one expected entry is consumed per clock, sampled 2 ns after the edge.
  always begin
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (observed !== e.v) begin
        errors++;
        $display("FAIL %s: got ctrl=%h t=%0d c=%b z=%b h=%b, want ctrl=%h t=%0d c=%b z=%b h=%b",
                 e.name, observed[19:6], observed[5:3], observed[2], observed[1], observed[0],
                 e.v[19:6], e.v[5:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic expect_state(input string name, input logic [13:0] ctrl, input logic [2:0] t,
                              input logic c, input logic z, input logic h);
    exp_t e;
    e.name = name;
    e.v    = {ctrl, t, c, z, h};
    q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic step();
    @(negedge clk);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Complete the current instruction: n_full steps normally, n_early with early end.
  task automatic finish_instr(input int n_full, input int n_early);
`ifdef SEQ_EARLY_END_EN
    steps(n_early);
`else
    steps(n_full);
`endif
  endtask

  task automatic pulse_reset(input logic with_step);
    @(negedge clk);
    rst_n   = 1'b0;
    step_en = with_step;
    @(negedge clk);
    rst_n   = 1'b1;
    step_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    step_en = 1'b0;
    opcode  = 4'b0001;
    alu_c   = 1'b0;
    alu_z   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LDA fetch and execute
    expect_state("rst_t0", FETCH0, 3'd0, 0, 0, 0);
    step(); expect_state("lda_t1", RAM_OUT | IR_IN | PC_INC, 3'd1, 0, 0, 0);
    step(); expect_state("lda_t2", IR_OUT | MAR_IN, 3'd2, 0, 0, 0);
    step(); expect_state("lda_t3", RAM_OUT | A_IN, 3'd3, 0, 0, 0);
    step();
`ifdef SEQ_EARLY_END_EN
    expect_state("lda_wrap", FETCH0, 3'd0, 0, 0, 0);
`else
    expect_state("lda_t4", 14'h0, 3'd4, 0, 0, 0);
    step(); expect_state("lda_wrap", FETCH0, 3'd0, 0, 0, 0);
`endif

    // ADD captures C=1, Z=0 on its final step
    opcode = 4'b0010; alu_c = 1'b1; alu_z = 1'b0;
    steps(2); expect_state("add_t2", IR_OUT | MAR_IN, 3'd2, 0, 0, 0);
    step();   expect_state("add_t3", RAM_OUT | B_IN, 3'd3, 0, 0, 0);
    step();   expect_state("add_t4", ALU_OUT | A_IN, 3'd4, 0, 0, 0);
    step();   expect_state("add_flags", FETCH0, 3'd0, 1, 0, 0);

    // JC taken on registered C (live carry low), JZ not taken
    opcode = 4'b0111; alu_c = 1'b0;
    steps(2); expect_state("jc_t2", IR_OUT | PC_JUMP, 3'd2, 1, 0, 0);
    finish_instr(3, 1);
    opcode = 4'b1000; alu_z = 1'b1;
    steps(2); expect_state("jz_t2", IR_OUT, 3'd2, 1, 0, 0);
    finish_instr(3, 1);

    // SUB captures C=0, Z=1
    opcode = 4'b0011; alu_c = 1'b0; alu_z = 1'b1;
    steps(4); expect_state("sub_t4", ALU_OUT | A_IN | ALU_SUB, 3'd4, 1, 0, 0);
    step();   expect_state("sub_flags", FETCH0, 3'd0, 0, 1, 0);
    opcode = 4'b1000; alu_z = 1'b0;
    steps(2); expect_state("jz_taken", IR_OUT | PC_JUMP, 3'd2, 0, 1, 0);
    finish_instr(3, 1);

    // STA, JMP, OUT, undefined opcode
    opcode = 4'b0100;
    steps(2); expect_state("sta_t2", IR_OUT | MAR_IN, 3'd2, 0, 1, 0);
    step();   expect_state("sta_t3", A_OUT | RAM_IN, 3'd3, 0, 1, 0);
    finish_instr(2, 1);
    opcode = 4'b0110;
    steps(2); expect_state("jmp_t2", IR_OUT | PC_JUMP, 3'd2, 0, 1, 0);
    finish_instr(3, 1);
    opcode = 4'b1110;
    steps(2); expect_state("out_t2", A_OUT | OUT_IN, 3'd2, 0, 1, 0);
    finish_instr(3, 1);
    opcode = 4'b1010;
    steps(2); expect_state("undef_t2", 14'h0, 3'd2, 0, 1, 0);
    finish_instr(3, 1);
    expect_state("undef_end", FETCH0, 3'd0, 0, 1, 0);

    // LDI instruction length
    opcode = 4'b0101;
    steps(2); expect_state("ldi_t2", IR_OUT | A_IN, 3'd2, 0, 1, 0);
    step();
`ifdef SEQ_EARLY_END_EN
    expect_state("ldi_wrap", FETCH0, 3'd0, 0, 1, 0);
`else
    expect_state("ldi_t3", 14'h0, 3'd3, 0, 1, 0);
    step(); expect_state("ldi_t4", 14'h0, 3'd4, 0, 1, 0);
    step(); expect_state("ldi_wrap", FETCH0, 3'd0, 0, 1, 0);
`endif

    // HLT latches at T2 and freezes until reset
    opcode = 4'b1111;
    steps(2); expect_state("hlt_t2", 14'h0, 3'd2, 0, 1, 0);
    step();   expect_state("hlt_set", 14'h0, 3'd2, 0, 1, 1);
    opcode = 4'b0001;
    steps(10); expect_state("hlt_frozen", 14'h0, 3'd2, 0, 1, 1);
    pulse_reset(1'b0);
    expect_state("hlt_reset", FETCH0, 3'd0, 0, 0, 0);

    // Reset beats step_en mid-ADD with both flags set
    opcode = 4'b0010; alu_c = 1'b1; alu_z = 1'b1;
    steps(5); expect_state("add11_flags", FETCH0, 3'd0, 1, 1, 0);
    steps(3); expect_state("add_t3b", RAM_OUT | B_IN, 3'd3, 1, 1, 0);
    pulse_reset(1'b1);
    expect_state("rst_over_step", FETCH0, 3'd0, 0, 0, 0);

    // No step_en for 100 clocks: nothing moves even with changing inputs
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      opcode = 4'(i);
      alu_c  = i[0];
      alu_z  = i[1];
    end
    opcode = 4'b0010;
    expect_state("idle_100", FETCH0, 3'd0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
